// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage: PC/instruction widths, FSM states, output record.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package instr_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  typedef logic [PC_W-1:0]    ProgramCounter;
  typedef logic [INSTR_W-1:0] Instruction;

  // IDLE: nothing outstanding; WAIT: one request outstanding, keep its data;
  // DROP: one request outstanding, its data is stale and must be discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // What the decode stage sees.
  typedef struct packed {
    logic          valid;
    Instruction    instr;
    ProgramCounter pc;
  } F_output;

  // One instruction queue slot: the word plus the PC it was fetched from.
  typedef struct packed {
    ProgramCounter pc;
    Instruction    instr;
  } q_entry_t;

  // Sequential fetch: word index + 1, wrapping 255 -> 0 through the 8-bit width.
  function automatic ProgramCounter pc_next(input ProgramCounter pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode, QDEPTH entries, flushable.
// Latency: an entry enqueued in cycle N is visible on head in cycle N+1.
// Backpressure: none internally; the producer must only enqueue when count < QDEPTH.
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq,
  input  q_entry_t                 enq_entry,
  input  logic                     deq,
  input  logic                     flush,
  output logic [$clog2(QDEPTH):0]  count,
  output q_entry_t                 head
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  q_entry_t         mem_q [QDEPTH];

  // Pointer/count update; flush wins over any enqueue or dequeue in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem_q[wr_ptr_q] <= enq_entry;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, single-outstanding request FSM, response tagging into a queue.
// Latency: request accepted in N, response in N+k enqueues, visible to decode in N+k+1.
// Backpressure: requests only issue while the queue has a free slot; decode stalls via out_ready.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        req_valid,
  output logic [7:0]  req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [7:0]  out_pc,
  input  logic        out_ready
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e  state_q, state_d;
  ProgramCounter pc_q, pc_d;
  ProgramCounter tag_q, tag_d;

  logic [CNT_W-1:0] q_count;
  q_entry_t         q_head;
  q_entry_t         enq_entry;
  logic             req_fire;
  logic             enq;
  logic             deq;
  F_output          fout;

  // Credit rule: the registered count guarantees a free slot for the single outstanding response.
  assign req_valid = reset && (state_q == IDLE) && !redirect && (q_count < CNT_W'(QDEPTH));
  assign req_addr  = pc_q;
  assign req_fire  = req_valid && req_ready;

  // A response is kept only in WAIT and only if no redirect lands in the same cycle.
  assign enq       = (state_q == WAIT) && resp_valid && !redirect;
  assign enq_entry = '{pc: tag_q, instr: resp_data};

  // Decode-facing view of the queue head; a redirect cycle hands nothing over.
  always_comb begin
    fout.valid = (q_count != '0) && !redirect;
    fout.instr = q_head.instr;
    fout.pc    = q_head.pc;
  end

  assign deq       = fout.valid && out_ready;
  assign out_valid = fout.valid;
  assign out_instr = fout.instr;
  assign out_pc    = fout.pc;

  // Next-state, PC and tag computation for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tag_d   = tag_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = WAIT;
          tag_d   = pc_q;
        end
      end
      WAIT: begin
        // Response with a redirect is dropped but still completes the request.
        if (resp_valid)    state_d = IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP: begin
        if (resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect)      pc_d = redirect_pc;
    else if (req_fire) pc_d = pc_next(pc_q);
  end

  // FSM, PC and response-tag registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .enq       (enq),
    .enq_entry (enq_entry),
    .deq       (deq),
    .flush     (redirect),
    .count     (q_count),
    .head      (q_head)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle table, hand-written corner sequences, randomized run.
// Latency: n/a.
// Backpressure: memory and decode are modelled with random ready/latency.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        req_valid;
  logic [7:0]  req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        out_ready = 1'b0;

  instr_fetch #(.QDEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model state and decode-side scoreboard.
  bit         pend = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  int         pend_timer = 0;
  int         lat_lo = 0;
  logic [7:0] exp_out_pc = 8'h00;
  logic [7:0] exp_req_pc = 8'h00;
  int         delivered = 0;
  int         issued = 0;
  logic [7:0] seen_pc[$];

  typedef struct {
    bit         rdr;
    logic [7:0] rpc;
    bit         rrdy;
    bit         rvld;
    logic [31:0] rdat;
    bit         ordy;
    bit         e_req;
    logic [7:0] e_addr;
    bit         e_out;
    logic [7:0] e_pc;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'h1000_0000 + {24'd0, a};
  endfunction

  function automatic vec_t mk(input bit rdr, input logic [7:0] rpc, input bit rrdy, input bit rvld,
                              input logic [7:0] rtag, input bit ordy, input bit e_req,
                              input logic [7:0] e_addr, input bit e_out, input logic [7:0] e_pc);
    vec_t v;
    v.rdr = rdr; v.rpc = rpc; v.rrdy = rrdy; v.rvld = rvld; v.rdat = mem_word(rtag);
    v.ordy = ordy; v.e_req = e_req; v.e_addr = e_addr; v.e_out = e_out; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; redirect = 1'b0; req_ready = 1'b1; resp_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_req_valid", {31'd0, req_valid}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("reset_req_valid_hold", {31'd0, req_valid}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    pend = 1'b0; exp_out_pc = 8'h00; exp_req_pc = 8'h00;
    delivered = 0; issued = 0; seen_pc.delete();
  endtask

  // One cycle with the memory model answering and the scoreboard tracking decode.
  task automatic step(input bit rdr, input logic [7:0] rpc, input bit ordy, input int rdy_pct,
                      input int lat_max, input bit stale);
    @(negedge clk);
    redirect = rdr; redirect_pc = rpc; out_ready = ordy;
    if (stale) begin
      resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF; req_ready = 1'b0;
    end else begin
      if (pend && pend_timer == 0) begin
        resp_valid = 1'b1; resp_data = mem_word(pend_addr); pend = 1'b0;
      end else begin
        resp_valid = 1'b0; resp_data = $urandom;
        if (pend) pend_timer--;
      end
      req_ready = ($urandom_range(99) < rdy_pct);
    end
    #1;
    if (rdr) begin
      chk("no_handoff_on_redirect", {31'd0, out_valid}, 32'd0);
      chk("no_request_on_redirect", {31'd0, req_valid}, 32'd0);
    end
    if (req_valid && req_ready) begin
      chk("single_outstanding", {31'd0, pend}, 32'd0);
      chk("req_addr", {24'd0, req_addr}, {24'd0, exp_req_pc});
      exp_req_pc = exp_req_pc + 8'd1;
      pend = 1'b1; pend_addr = req_addr; issued++;
      pend_timer = $urandom_range(lat_max - 1, lat_lo);
    end
    if (rdr) begin
      exp_req_pc = rpc;
      exp_out_pc = rpc;
    end else if (out_valid && out_ready) begin
      chk("out_pc", {24'd0, out_pc}, {24'd0, exp_out_pc});
      chk("out_instr", out_instr, mem_word(exp_out_pc));
      seen_pc.push_back(out_pc);
      exp_out_pc = exp_out_pc + 8'd1;
      delivered++;
    end
  endtask

  task automatic run_until(input int want, input int budget, input string name);
    int n;
    n = 0;
    while (delivered < want && n < budget) begin
      step(1'b0, 8'h00, 1'b1, 100, 1, 1'b0);
      n++;
    end
    chk(name, {31'd0, delivered >= want}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    logic [7:0] exp_seq[4];

    // Directed cycle table: zero-wait fetch, queue fill/drain, redirect with response, redirect in WAIT.
    //          rdr rpc   rrdy rvld tag   ordy ereq eaddr eout epc
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h01, 1, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h01, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h02, 1, 8'h01));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h02, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h03, 1, 8'h02));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h03, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h04, 1, 8'h03));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h04, 0, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h05, 1, 8'h04));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h05, 0, 0, 8'h00, 1, 8'h04));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h04));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 8'h00, 1, 8'h04));
    vt.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h06, 1, 8'h05));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h06, 0, 8'h00));
    vt.push_back(mk(1, 8'h10, 1, 1, 8'h06, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h10, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h10, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h11, 1, 8'h10));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h11, 0, 8'h00));
    vt.push_back(mk(1, 8'h40, 1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h11, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h40, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h40, 1, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h41, 1, 8'h40));
    vt.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h41, 0, 8'h00));

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      redirect = vt[i].rdr; redirect_pc = vt[i].rpc; req_ready = vt[i].rrdy;
      resp_valid = vt[i].rvld; resp_data = vt[i].rdat; out_ready = vt[i].ordy;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), {31'd0, req_valid}, {31'd0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("tbl%0d_req_addr", i), {24'd0, req_addr}, {24'd0, vt[i].e_addr});
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_out});
      if (vt[i].e_out) begin
        chk($sformatf("tbl%0d_out_pc", i), {24'd0, out_pc}, {24'd0, vt[i].e_pc});
        chk($sformatf("tbl%0d_out_instr", i), out_instr, mem_word(vt[i].e_pc));
      end
    end

    // Decode stalled: queue fills with pc 0,1 and fetching stops; release drains in order.
    do_reset();
    lat_lo = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 100, 1, 1'b0);
    chk("stall_issued", issued, 2);
    chk("stall_req_valid", {31'd0, req_valid}, 32'd0);
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_head_pc", {24'd0, out_pc}, 32'd0);
    run_until(3, 30, "stall_drain_progress");
    exp_seq = '{8'h00, 8'h01, 8'h02, 8'h00};
    for (int i = 0; i < 3 && i < seen_pc.size(); i++)
      chk($sformatf("stall_order%0d", i), {24'd0, seen_pc[i]}, {24'd0, exp_seq[i]});

    // PC wrap from 0xFF to 0x00.
    do_reset();
    step(1'b1, 8'hFE, 1'b1, 100, 1, 1'b0);
    run_until(4, 40, "wrap_progress");
    exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 4 && i < seen_pc.size(); i++)
      chk($sformatf("wrap_pc%0d", i), {24'd0, seen_pc[i]}, {24'd0, exp_seq[i]});

    // Redirect while waiting, then a second redirect while dropping: last target wins.
    do_reset();
    lat_lo = 2;
    step(1'b0, 8'h00, 1'b1, 100, 3, 1'b0);
    step(1'b1, 8'h20, 1'b1, 100, 3, 1'b0);
    step(1'b1, 8'h30, 1'b1, 100, 3, 1'b0);
    lat_lo = 0;
    run_until(2, 30, "drop_progress");
    if (seen_pc.size() >= 2) begin
      chk("drop_first_pc", {24'd0, seen_pc[0]}, 32'h30);
      chk("drop_second_pc", {24'd0, seen_pc[1]}, 32'h31);
    end

    // Reset during WAIT; the stale response after release must be ignored.
    do_reset();
    lat_lo = 2;
    step(1'b0, 8'h00, 1'b1, 100, 3, 1'b0);
    lat_lo = 0;
    do_reset();
    step(1'b0, 8'h00, 1'b1, 0, 1, 1'b1);
    chk("rst_stale_req_valid", {31'd0, req_valid}, 32'd1);
    chk("rst_stale_req_addr", {24'd0, req_addr}, 32'd0);
    run_until(1, 20, "rst_first_out");
    if (seen_pc.size() >= 1) chk("rst_first_pc", {24'd0, seen_pc[0]}, 32'd0);

    // Randomized traffic against the scoreboard.
    do_reset();
    lat_lo = 0;
    for (int i = 0; i < 3000; i++) begin
      logic       rdr;
      logic [7:0] rpc;
      rdr = ($urandom_range(99) < 4);
      rpc = 8'($urandom);
      step(rdr, rpc, ($urandom_range(99) < 60), 75, 3, 1'b0);
    end
    chk("random_progress", {31'd0, delivered > 200}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
